// File: rtl/game_pkg.sv
// Shared encodings for the Tetris play controller.
// Contents: movement command codes, sequencer state codes, row-count saturation limit.
package game_pkg;

    // Movement codes. A button's index in the priority vector equals its code.
    typedef enum logic [2:0] {
        MV_CW    = 3'd0,
        MV_ACW   = 3'd1,
        MV_DOWN  = 3'd2,
        MV_LEFT  = 3'd3,
        MV_RIGHT = 3'd4,
        MV_NONE  = 3'd5
    } move_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SPAWN  = 3'd1,
        ST_FALL   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_OVER   = 3'd4
    } state_e;

    localparam logic [13:0] ROWS_SAT  = 14'd9999;
    localparam logic [3:0]  LEVEL_MAX = 4'd15;

endpackage

// File: rtl/button_repeat.sv
// Rising-edge detect and hold auto-repeat for one debounced button.
// Ports:
//   clk, reset, ce   clock, async active-high reset, clock enable
//   i_btn            debounced button level
//   i_frame_tick     one-ce pulse per video frame
//   i_rep_en         1 = button auto-repeats while held
//   i_active         1 = commands may be issued (sequencer in FALL)
//   o_rise           raw rising edge this cycle, regardless of i_active
//   o_req            command request: edge, or every REPEAT_FRAMES-th frame held
module button_repeat
    import game_pkg::*;
#(
    parameter int unsigned REPEAT_FRAMES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic i_btn,
    input  logic i_frame_tick,
    input  logic i_rep_en,
    input  logic i_active,
    output logic o_rise,
    output logic o_req
);

    localparam int unsigned CW = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;

    logic          r_prev;
    logic [CW-1:0] r_cnt;
    logic          w_rise;
    logic          w_count;
    logic          w_wrap;

    assign w_rise  = i_btn & ~r_prev;
    // Held past its edge: frame ticks accumulate only here; the edge cycle itself does not count.
    assign w_count = i_btn & r_prev & i_rep_en & i_active;
    assign w_wrap  = (r_cnt == CW'(REPEAT_FRAMES - 1));

    assign o_rise = w_rise;
    assign o_req  = i_active & (w_rise | (w_count & i_frame_tick & w_wrap));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= 1'b0;
            r_cnt  <= '0;
        end else if (ce) begin
            r_prev <= i_btn;
            if (!w_count) begin
                r_cnt <= '0;
            end else if (i_frame_tick) begin
                r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Top-level Tetris play controller: spawn/gravity timing, button arbitration,
// row/level bookkeeping and the game-over hold.
// Ports:
//   clk, reset, ce          clock, async active-high reset, clock enable
//   frame_tick              one-ce pulse per video frame
//   *_db                    debounced button levels
//   velocity                player speed select
//   settle_done/rows_cleared  piece locked; rows removed (valid with settle_done)
//   game_over_logic         board overflow flag
//   movement/move_strobe    registered movement command and its one-ce strobe
//   spawn_req               one-ce new-piece request
//   playing                 high in SPAWN, FALL, SETTLE
//   level, total_rows       saturating progress counters
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned BASE_FALL_FRAMES = 48,
    parameter int unsigned MIN_FALL_FRAMES  = 4,
    parameter int unsigned REPEAT_FRAMES    = 8,
    parameter int unsigned LINES_PER_LEVEL  = 10,
    parameter int unsigned OVER_HOLD_FRAMES = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        frame_tick,
    input  logic        clockwise_db,
    input  logic        anti_clkwise_db,
    input  logic        down_db,
    input  logic        left_db,
    input  logic        right_db,
    input  logic [1:0]  velocity,
    input  logic        settle_done,
    input  logic [2:0]  rows_cleared,
    input  logic        game_over_logic,
    output logic [2:0]  movement,
    output logic        move_strobe,
    output logic        spawn_req,
    output logic        playing,
    output logic [3:0]  level,
    output logic [13:0] total_rows
);

    localparam int unsigned OW = $clog2(OVER_HOLD_FRAMES + 1);
    // Rotations never repeat; down/left/right do.
    localparam logic [4:0] REP_EN = 5'b11100;

    state_e        r_state, w_state_d;
    move_e         r_movement, w_movement_d;
    logic          r_move_strobe, w_strobe_d;
    logic          r_spawn_req;
    logic          r_playing;
    logic [3:0]    r_level, w_level_d;
    logic [13:0]   r_total, w_total_d;
    logic [7:0]    r_grav_cnt, w_grav_d;
    logic          r_grav_pend, w_pend_d;
    logic [OW-1:0] r_over_cnt, w_over_d;

    logic [4:0]  w_btn, w_rise, w_req;
    logic        w_fall, w_live;
    logic        w_cmd_valid;
    move_e       w_cmd;
    logic [7:0]  w_slow, w_period;
    logic        w_grav_exp, w_grav_hit;
    logic [14:0] w_sum;
    logic [13:0] w_total_sat, w_level_full;
    logic [3:0]  w_level_sat;

    // Bit index == movement code == priority (lowest index wins).
    assign w_btn  = {right_db, left_db, down_db, anti_clkwise_db, clockwise_db};
    assign w_fall = (r_state == ST_FALL);
    assign w_live = (r_state == ST_SPAWN) || (r_state == ST_FALL) || (r_state == ST_SETTLE);

    for (genvar gi = 0; gi < 5; gi++) begin : g_btn
        button_repeat #(
            .REPEAT_FRAMES (REPEAT_FRAMES)
        ) u_btn (
            .clk          (clk),
            .reset        (reset),
            .ce           (ce),
            .i_btn        (w_btn[gi]),
            .i_frame_tick (frame_tick),
            .i_rep_en     (REP_EN[gi]),
            .i_active     (w_fall),
            .o_rise       (w_rise[gi]),
            .o_req        (w_req[gi])
        );
    end

    always_comb begin
        w_cmd_valid = 1'b0;
        w_cmd       = MV_NONE;
        for (int i = 4; i >= 0; i--) begin
            if (w_req[i]) begin
                w_cmd_valid = 1'b1;
                w_cmd       = move_e'(3'(i));
            end
        end
    end

    // Gravity period, clamped before subtraction so it can never wrap.
    assign w_slow     = {2'b00, r_level, 2'b00} + {3'b000, velocity, 3'b000};
    assign w_period   = (w_slow + 8'(MIN_FALL_FRAMES) >= 8'(BASE_FALL_FRAMES)) ?
                        8'(MIN_FALL_FRAMES) : 8'(BASE_FALL_FRAMES) - w_slow;
    assign w_grav_exp = (r_grav_cnt + 8'd1 >= w_period);

    assign w_sum        = {1'b0, r_total} + {12'd0, rows_cleared};
    assign w_total_sat  = (w_sum > {1'b0, ROWS_SAT}) ? ROWS_SAT : w_sum[13:0];
    assign w_level_full = w_total_sat / 14'(LINES_PER_LEVEL);
    assign w_level_sat  = (w_level_full > {10'd0, LEVEL_MAX}) ? LEVEL_MAX : w_level_full[3:0];

    always_comb begin
        w_state_d    = r_state;
        w_movement_d = MV_NONE;
        w_strobe_d   = 1'b0;
        w_pend_d     = 1'b0;
        w_grav_d     = '0;
        w_over_d     = '0;
        w_total_d    = r_total;
        w_level_d    = r_level;
        w_grav_hit   = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (|w_rise) begin
                    w_state_d = ST_SPAWN;
                    w_total_d = '0;
                    w_level_d = '0;
                end
            end
            ST_SPAWN: w_state_d = ST_FALL;
            ST_FALL: begin
                w_grav_d = r_grav_cnt;
                w_pend_d = r_grav_pend;
                if (frame_tick) begin
                    if (w_grav_exp) begin
                        w_grav_d   = '0;
                        w_grav_hit = 1'b1;
                    end else begin
                        w_grav_d = r_grav_cnt + 8'd1;
                    end
                end
                // A button wins the slot; gravity waits one cycle (expiries merge).
                if (w_cmd_valid) begin
                    w_strobe_d   = 1'b1;
                    w_movement_d = w_cmd;
                    w_pend_d     = r_grav_pend | w_grav_hit;
                end else if (r_grav_pend | w_grav_hit) begin
                    w_strobe_d   = 1'b1;
                    w_movement_d = MV_NONE;
                    w_pend_d     = 1'b0;
                end
                if (settle_done) begin
                    w_state_d = ST_SETTLE;
                    w_pend_d  = 1'b0;
                    w_total_d = w_total_sat;
                    w_level_d = w_level_sat;
                end
            end
            ST_SETTLE: w_state_d = ST_SPAWN;
            ST_OVER: begin
                w_over_d = r_over_cnt;
                if (frame_tick) begin
                    if (r_over_cnt == OW'(OVER_HOLD_FRAMES - 1)) begin
                        w_state_d = ST_IDLE;
                        w_over_d  = '0;
                    end else begin
                        w_over_d = r_over_cnt + 1'b1;
                    end
                end
            end
            default: w_state_d = ST_IDLE;
        endcase

        // Overflow beats every other transition and suppresses this cycle's command.
        if (w_live && game_over_logic) begin
            w_state_d    = ST_OVER;
            w_strobe_d   = 1'b0;
            w_movement_d = MV_NONE;
            w_pend_d     = 1'b0;
            w_grav_d     = '0;
            w_total_d    = r_total;
            w_level_d    = r_level;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_movement    <= MV_NONE;
            r_move_strobe <= 1'b0;
            r_spawn_req   <= 1'b0;
            r_playing     <= 1'b0;
            r_level       <= '0;
            r_total       <= '0;
            r_grav_cnt    <= '0;
            r_grav_pend   <= 1'b0;
            r_over_cnt    <= '0;
        end else if (ce) begin
            r_state       <= w_state_d;
            r_movement    <= w_movement_d;
            r_move_strobe <= w_strobe_d;
            r_spawn_req   <= (w_state_d == ST_SPAWN);
            r_playing     <= (w_state_d == ST_SPAWN) || (w_state_d == ST_FALL) ||
                             (w_state_d == ST_SETTLE);
            r_level       <= w_level_d;
            r_total       <= w_total_d;
            r_grav_cnt    <= w_grav_d;
            r_grav_pend   <= w_pend_d;
            r_over_cnt    <= w_over_d;
        end
    end

    assign movement    = r_movement;
    assign move_strobe = r_move_strobe;
    assign spawn_req   = r_spawn_req;
    assign playing     = r_playing;
    assign level       = r_level;
    assign total_rows  = r_total;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a frame-level reference model queues the
// expected strobes, spawns and status per ce cycle; a negedge monitor pops and compares.
module tb_game_sequencer;

    localparam int BASE = 48, MINF = 4, REP = 8, LPL = 10, HOLD = 120, FDIV = 3;
    localparam int P_IDLE = 0, P_SPAWN = 1, P_FALL = 2, P_SETTLE = 3, P_OVER = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce, frame_tick;
    logic        cw, acw, dn, lf, rt;
    logic [1:0]  velocity;
    logic        settle_done;
    logic [2:0]  rows_cleared;
    logic        game_over_logic;
    logic [2:0]  movement;
    logic        move_strobe, spawn_req, playing;
    logic [3:0]  level;
    logic [13:0] total_rows;

    game_sequencer #(
        .BASE_FALL_FRAMES (BASE),
        .MIN_FALL_FRAMES  (MINF),
        .REPEAT_FRAMES    (REP),
        .LINES_PER_LEVEL  (LPL),
        .OVER_HOLD_FRAMES (HOLD)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ce              (ce),
        .frame_tick      (frame_tick),
        .clockwise_db    (cw),
        .anti_clkwise_db (acw),
        .down_db         (dn),
        .left_db         (lf),
        .right_db        (rt),
        .velocity        (velocity),
        .settle_done     (settle_done),
        .rows_cleared    (rows_cleared),
        .game_over_logic (game_over_logic),
        .movement        (movement),
        .move_strobe     (move_strobe),
        .spawn_req       (spawn_req),
        .playing         (playing),
        .level           (level),
        .total_rows      (total_rows)
    );

    always #5 clk = ~clk;

    typedef struct { int tag; int val; } ev_t;
    typedef struct { int tag; int ply; int lvl; int tot; } st_t;

    ev_t mvq[$];
    ev_t spq[$];
    st_t stq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int ce_count = 0;
    int last_seen = 0;
    int fcnt = 0;
    bit mon_on = 0;
    bit ce_rand = 0;

    // Reference model state
    int m_phase;
    bit m_prev[5];
    int m_held[5];
    int m_grav, m_over, m_total, m_level;
    bit m_pend;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (ce cycle %0d)", name, act, exp, ce_count);
        end
    endtask

    function automatic int period(input int lvl, input int vel);
        int p;
        p = BASE - 4 * lvl - 8 * vel;
        return (p < MINF) ? MINF : p;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_grav = 0; m_over = 0; m_total = 0; m_level = 0; m_pend = 0;
        for (int i = 0; i < 5; i++) begin
            m_prev[i] = 0;
            m_held[i] = 0;
        end
    endtask

    // One ce cycle of the game rules; expectations are for the following ce cycle.
    task automatic model_step();
        int tag = ce_count + 1;
        bit btn[5];
        bit rise[5];
        bit fire[5];
        bit any_rise = 0;
        bit hit = 0;
        int cmd = -1;
        int nxt;
        btn = '{cw, acw, dn, lf, rt};
        nxt = m_phase;
        for (int i = 0; i < 5; i++) begin
            rise[i] = btn[i] && !m_prev[i];
            fire[i] = 0;
            if (rise[i]) any_rise = 1;
            if (m_phase != P_FALL || !btn[i] || rise[i]) m_held[i] = 0;
            else if (frame_tick) begin
                m_held[i]++;
                fire[i] = (i >= 2) && (m_held[i] % REP == 0);
            end
        end
        if (m_phase == P_FALL)
            for (int i = 4; i >= 0; i--) if (rise[i] || fire[i]) cmd = i;
        case (m_phase)
            P_IDLE: if (any_rise) begin
                nxt = P_SPAWN; m_total = 0; m_level = 0;
            end
            P_SPAWN: nxt = P_FALL;
            P_FALL: begin
                if (frame_tick) begin
                    m_grav++;
                    if (m_grav >= period(m_level, int'(velocity))) begin
                        hit = 1; m_grav = 0;
                    end
                end
                if (!game_over_logic) begin
                    if (cmd >= 0) begin
                        mvq.push_back('{tag, cmd});
                        m_pend = m_pend || hit;
                    end else if (m_pend || hit) begin
                        mvq.push_back('{tag, 5});
                        m_pend = 0;
                    end
                    if (settle_done) begin
                        nxt = P_SETTLE;
                        m_total = m_total + int'(rows_cleared);
                        if (m_total > 9999) m_total = 9999;
                        m_level = m_total / LPL;
                        if (m_level > 15) m_level = 15;
                    end
                end
            end
            P_SETTLE: nxt = P_SPAWN;
            P_OVER: if (frame_tick) begin
                m_over++;
                if (m_over == HOLD) nxt = P_IDLE;
            end
            default: nxt = P_IDLE;
        endcase
        if (game_over_logic && (m_phase == P_SPAWN || m_phase == P_FALL || m_phase == P_SETTLE))
            nxt = P_OVER;
        if (nxt != P_FALL) begin m_grav = 0; m_pend = 0; end
        if (nxt != P_OVER) m_over = 0;
        if (nxt == P_SPAWN) spq.push_back('{tag, 1});
        stq.push_back('{tag, (nxt == P_SPAWN || nxt == P_FALL || nxt == P_SETTLE) ? 1 : 0,
                       m_level, m_total});
        m_phase = nxt;
        for (int i = 0; i < 5; i++) m_prev[i] = btn[i];
    endtask

    always @(posedge clk) if (!reset && ce) ce_count <= ce_count + 1;

    // Monitor: once per ce cycle, pop and compare whatever the model expected for it.
    always @(negedge clk) begin
        if (mon_on && !reset && ce_count != last_seen) begin
            last_seen = ce_count;
            if (stq.size() == 0) check("status_present", 0, 1);
            else begin
                check("status_tag", stq[0].tag, ce_count);
                check("playing", int'(playing), stq[0].ply);
                check("level", int'(level), stq[0].lvl);
                check("total_rows", int'(total_rows), stq[0].tot);
                void'(stq.pop_front());
            end
            if (mvq.size() != 0 && mvq[0].tag == ce_count) begin
                check("move_strobe", int'(move_strobe), 1);
                check("movement", int'(movement), mvq[0].val);
                void'(mvq.pop_front());
            end else begin
                check("move_quiet", int'(move_strobe), 0);
            end
            if (spq.size() != 0 && spq[0].tag == ce_count) begin
                check("spawn_req", int'(spawn_req), 1);
                void'(spq.pop_front());
            end else begin
                check("spawn_quiet", int'(spawn_req), 0);
            end
        end
    end

    task automatic step(input logic [4:0] b, input bit sd, input int rows, input bit go);
        ce = ce_rand ? ($urandom_range(0, 7) != 0) : 1'b1;
        {rt, lf, dn, acw, cw} = b;
        settle_done = sd;
        rows_cleared = 3'(rows);
        game_over_logic = go;
        frame_tick = 1'b0;
        if (ce) begin
            fcnt++;
            frame_tick = (fcnt % FDIV == 0);
            model_step();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(5'b00000, 0, 0, 0);
    endtask

    // Asynchronous reset: outputs must return to reset values without a clock edge.
    task automatic do_reset(input string name);
        reset = 1'b1;
        ce = 1'b0;
        {rt, lf, dn, acw, cw} = 5'b00000;
        settle_done = 1'b0;
        rows_cleared = 3'd0;
        game_over_logic = 1'b0;
        frame_tick = 1'b0;
        mvq.delete(); spq.delete(); stq.delete();
        #2;
        check({name, "_movement"}, int'(movement), 5);
        check({name, "_strobe"}, int'(move_strobe), 0);
        check({name, "_spawn"}, int'(spawn_req), 0);
        check({name, "_playing"}, int'(playing), 0);
        check({name, "_level"}, int'(level), 0);
        check({name, "_rows"}, int'(total_rows), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        last_seen = ce_count;
    endtask

    initial begin
        logic [4:0] cur;
        velocity = 2'd0;
        model_reset();
        do_reset("reset0");
        mon_on = 1;

        // Start a game with right, then cw+left together in FALL
        step(5'b10000, 0, 0, 0);
        idle(4);
        step(5'b01001, 0, 0, 0);
        idle(3);

        // Hold left for 20 frames
        for (int k = 0; k < 20 * FDIV; k++) step(5'b01000, 0, 0, 0);
        idle(2);

        // Gravity at velocity 2
        velocity = 2'd2;
        idle(70 * FDIV);

        // Three settles of four rows
        for (int k = 0; k < 3; k++) begin
            step(5'b00000, 1, 4, 0);
            idle(6);
        end
        check("rows_after_3", int'(total_rows), 12);
        check("level_after_3", int'(level), 1);

        // Up to level 10 at velocity 3: period clamps to the floor
        for (int k = 0; k < 22; k++) begin
            step(5'b00000, 1, 4, 0);
            idle(2);
        end
        velocity = 2'd3;
        idle(30 * FDIV);

        // Drive total_rows into saturation
        for (int k = 0; k < 2510; k++) begin
            step(5'b00000, 1, 4, 0);
            idle(2);
        end
        check("rows_saturated", int'(total_rows), 9999);
        check("level_saturated", int'(level), 15);

        // Randomized play with clock-enable gaps
        ce_rand = 1;
        cur = 5'b00000;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) cur[$urandom_range(0, 4)] ^= 1'b1;
            if ($urandom_range(0, 199) == 0) velocity = 2'($urandom_range(0, 3));
            step(cur, $urandom_range(0, 39) == 0, $urandom_range(0, 4), $urandom_range(0, 499) == 0);
        end
        ce_rand = 0;

        // Game over in FALL, full hold, back to IDLE, then a new game
        velocity = 2'd0;
        do_reset("reset1");
        step(5'b10000, 0, 0, 0);
        idle(10);
        step(5'b00000, 0, 0, 1);
        idle(HOLD * FDIV + 12);
        check("idle_after_hold", int'(playing), 0);
        step(5'b00100, 0, 0, 0);
        idle(6);
        step(5'b00000, 0, 0, 1);
        idle(50 * FDIV);

        // Reset in the middle of the game-over hold
        do_reset("reset_mid_hold");
        step(5'b01000, 0, 0, 0);
        idle(6);

        mon_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level play controller for the Tetris board.
- Decides when a new piece spawns and when gravity steps are issued.
- Arbitrates the five debounced player buttons into one movement command per step.
- Counts cleared rows into a level; runs the game-over hold before returning to idle.
- Sits between the debounced inputs and the piece-movement/settling logic; drives their movement, spawn and timing inputs.

Parameters:
- BASE_FALL_FRAMES, 48: gravity period in frames at level 0, velocity 0.
- MIN_FALL_FRAMES, 4: floor on the gravity period.
- REPEAT_FRAMES, 8: frames a held left/right/down button waits before re-issuing.
- LINES_PER_LEVEL, 10: cleared rows per level increment.
- OVER_HOLD_FRAMES, 120: frames spent in OVER before returning to IDLE.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- ce  in  1  clock enable; all state advances only on clk edges with ce=1
- frame_tick  in  1  one-ce-cycle pulse per video frame
- clockwise_db, anti_clkwise_db, down_db, left_db, right_db  in  1 each  debounced button levels
- velocity  in  2  player speed select
- settle_done  in  1  one-ce pulse: piece locked and row clearing finished
- rows_cleared  in  3  rows removed (0-4); valid with settle_done
- game_over_logic  in  1  board overflow flag
- movement  out  3  000 cw, 001 acw, 010 down, 011 left, 100 right, 101 gravity/none
- move_strobe  out  1  one-ce pulse; movement is valid this cycle
- spawn_req  out  1  one-ce pulse requesting a new piece
- playing  out  1  high in SPAWN, FALL, SETTLE
- level  out  4  current level, saturating at 15
- total_rows  out  14  rows cleared this game, saturating at 9999

Behaviour:
- Reset values: state IDLE, movement=101, move_strobe=0, spawn_req=0, playing=0, level=0, total_rows=0, all counters 0.
- All outputs are registered.

States:
- IDLE: leave on the rising edge of any button -> SPAWN. Level and rows are cleared on this transition.
- SPAWN: assert spawn_req for exactly one ce cycle, then go to FALL. The gravity counter is reloaded.
- FALL: command issue and gravity run here (rules below). settle_done -> SETTLE.
- SETTLE: add rows_cleared to total_rows (saturating at 9999). level = min(15, total_rows / LINES_PER_LEVEL). Next ce cycle -> SPAWN.
- OVER: all strobes are 0. Count OVER_HOLD_FRAMES frame_ticks, then -> IDLE. Buttons are ignored.
- game_over_logic=1 in SPAWN, FALL or SETTLE -> OVER on the next ce cycle. This has priority over every other transition.

Command issue in FALL:
- Button rising edge at ce cycle N -> move_strobe with that movement code at ce cycle N+1.
- Fixed priority when edges coincide: cw > acw > down > left > right. Losing edges in the same cycle are dropped, not queued.
- Held left/right/down re-issues on every REPEAT_FRAMES-th frame_tick while held. Rotations never repeat.
- At most one move_strobe per ce cycle.

Gravity in FALL:
- period = max(MIN_FALL_FRAMES, BASE_FALL_FRAMES - 4*level - 8*velocity). Use signed-safe arithmetic; no underflow wrap.
- The frame counter reaching period issues movement=101 with move_strobe and reloads the counter.
- Gravity coinciding with a button command: the button command goes first, gravity is held pending and issued on the next ce cycle.
- At most one pending gravity step; further expiries while pending are merged into it.

Other rules:
- settle_done outside FALL is ignored.
- settle_done in the same cycle as a command: the command is issued and the state still moves to SETTLE.
- Reset mid-operation returns to IDLE immediately and drops any pending strobe.
- ce=0 freezes everything, including pulses: a strobe pulse lasts exactly one ce cycle.

Decomposition:
- Shared package game_pkg holds:
  - movement encodings (MV_CW .. MV_NONE)
  - state encodings (ST_IDLE, ST_SPAWN, ST_FALL, ST_SETTLE, ST_OVER)
  - the 9999 saturation constant
- One sub-module, button_repeat, instantiated five times:
  - does rising-edge detection and the auto-repeat frame counter for one button
  - repeat enable is a port: tied 0 for the rotation buttons

Test Plan:
- Reset, then a right_db rising edge -> spawn_req pulses once; next state FALL; movement=101, level=0.
- In FALL, cw and left rise in the same ce cycle -> exactly one strobe with movement=000; left is dropped.
- Hold left_db for 20 frames, REPEAT_FRAMES=8 -> strobes with 011 at the edge+1 cycle, then at frames 8 and 16.
- velocity=2, level=0 -> gravity strobes every 32 frames. velocity=3, level=10 -> period clamps to 4.
- settle_done with rows_cleared=4, three times -> total_rows=12, level=1; spawn_req follows each settle by 2 ce cycles.
- game_over_logic in FALL -> playing=0 next cycle, no strobes for 120 frames, then IDLE. Assert reset mid-hold -> IDLE immediately with all outputs at reset values.
